// File: rtl/uart_packet_decoder.sv
// uart_packet_decoder
// Framing stage behind a UART byte receiver. Hunts for SYNC_BYTE, reads a word
// count, packs payload bytes little-endian into words, buffers them in a
// first-word-fall-through FIFO and verifies a trailing 8-bit checksum
// (sum of length and payload bytes, mod 256).
//
// Optional feature: define UART_PKT_TIMEOUT_EN to build an inter-byte timeout
// that aborts a stalled packet with an error pulse after TIMEOUT_CYCLES.
//
// Ports:
//   clk_in           system clock
//   rst_in           asynchronous active-high reset
//   byte_valid_in    one-cycle strobe qualifying byte_in
//   byte_in          received byte
//   word_valid_out   FIFO head valid
//   word_out         FIFO head word (first received byte in LSBs)
//   word_last_out    head word is the final word of its packet
//   word_ready_in    consumer accepts head when high with word_valid_out
//   packet_done_out  one-cycle pulse: packet complete, checksum good, no drops
//   error_out        one-cycle pulse: packet aborted or bad
//   idle_out         parser waiting for a sync byte
//
// State | meaning
// SYNC  | dropping bytes until SYNC_BYTE
// LEN   | next byte is the word count
// DATA  | collecting payload bytes
// CHK   | next byte is the checksum
module uart_packet_decoder #(
  parameter int          WORD_BYTES     = 4,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    byte_valid_in,
  input  logic [7:0]              byte_in,
  output logic                    word_valid_out,
  output logic [8*WORD_BYTES-1:0] word_out,
  output logic                    word_last_out,
  input  logic                    word_ready_in,
  output logic                    packet_done_out,
  output logic                    error_out,
  output logic                    idle_out
);

  localparam int WW  = 8 * WORD_BYTES;
  localparam int BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  typedef enum logic [1:0] {S_SYNC, S_LEN, S_DATA, S_CHK} state_t;

  state_t          r_state;
  logic [7:0]      r_len;
  logic [7:0]      r_sum;
  logic [7:0]      r_word_cnt;
  logic [BCW-1:0]  r_byte_cnt;
  logic            r_ovf;
  logic [WW-1:0]   r_word;
  logic            r_done;
  logic            r_err;

  logic [WW:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [WW-1:0]   w_word_next;
  logic            w_byte_last;
  logic            w_word_last;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_wr;
  logic            w_drop;
  logic            w_timeout;

  // Current word with the incoming byte dropped into its lane.
  always_comb begin
    w_word_next = r_word;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (r_byte_cnt == BCW'(k)) w_word_next[8*k +: 8] = byte_in;
    end
  end

  assign w_byte_last    = (r_byte_cnt == BCW'(WORD_BYTES - 1));
  assign w_word_last    = (r_word_cnt == (r_len - 8'd1));
  assign w_push         = byte_valid_in && (r_state == S_DATA) && w_byte_last;
  assign word_valid_out = (r_count != '0);
  assign w_pop          = word_valid_out && word_ready_in;
  assign w_full         = (r_count == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr           = w_push && (!w_full || w_pop);
  assign w_drop         = w_push && w_full && !w_pop;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;

  // Down-counter reloaded by every byte; terminal count mid-packet aborts.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_to_cnt <= '0;
    end else if (byte_valid_in) begin
      r_to_cnt <= TW'(TIMEOUT_CYCLES - 1);
    end else if (r_state != S_SYNC && r_to_cnt != '0) begin
      r_to_cnt <= r_to_cnt - TW'(1);
    end
  end

  assign w_timeout = (r_state != S_SYNC) && !byte_valid_in && (r_to_cnt == '0);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_SYNC;
      r_len      <= '0;
      r_sum      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_ovf      <= 1'b0;
      r_word     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_timeout) begin
        r_state <= S_SYNC;
        r_err   <= 1'b1;
      end else if (byte_valid_in) begin
        case (r_state)
          S_SYNC: begin
            if (byte_in == SYNC_BYTE) r_state <= S_LEN;
          end
          S_LEN: begin
            if (byte_in == 8'd0) begin
              r_state <= S_SYNC;
            end else begin
              r_len      <= byte_in;
              r_sum      <= byte_in;
              r_ovf      <= 1'b0;
              r_byte_cnt <= '0;
              r_word_cnt <= '0;
              r_word     <= '0;
              r_state    <= S_DATA;
            end
          end
          S_DATA: begin
            r_sum <= r_sum + byte_in;
            if (w_drop) r_ovf <= 1'b1;
            if (w_byte_last) begin
              r_byte_cnt <= '0;
              r_word     <= '0;
              r_word_cnt <= r_word_cnt + 8'd1;
              if (w_word_last) r_state <= S_CHK;
            end else begin
              r_byte_cnt <= r_byte_cnt + BCW'(1);
              r_word     <= w_word_next;
            end
          end
          S_CHK: begin
            if (byte_in == r_sum && !r_ovf) r_done <= 1'b1;
            else                            r_err  <= 1'b1;
            r_state <= S_SYNC;
          end
          default: r_state <= S_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= {w_word_last, w_word_next};
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign word_out        = word_valid_out ? r_mem[r_rd_ptr][WW-1:0] : '0;
  assign word_last_out   = word_valid_out ? r_mem[r_rd_ptr][WW]     : 1'b0;
  assign packet_done_out = r_done;
  assign error_out       = r_err;
  assign idle_out        = (r_state == S_SYNC);

endmodule

// File: tb/tb_uart_packet_decoder.sv
module tb_uart_packet_decoder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        byte_valid_in = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        word_valid_out;
  logic [31:0] word_out;
  logic        word_last_out;
  logic        word_ready_in = 1'b1;
  logic        packet_done_out;
  logic        error_out;
  logic        idle_out;

  int tests = 0;
  int fails = 0;

  uart_packet_decoder #(
    .WORD_BYTES     (4),
    .FIFO_DEPTH     (2),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .byte_valid_in   (byte_valid_in),
    .byte_in         (byte_in),
    .word_valid_out  (word_valid_out),
    .word_out        (word_out),
    .word_last_out   (word_last_out),
    .word_ready_in   (word_ready_in),
    .packet_done_out (packet_done_out),
    .error_out       (error_out),
    .idle_out        (idle_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe one byte; returns 1ns after the capturing edge.
  task automatic send(input logic [7:0] b);
    @(posedge clk_in); #1;
    byte_valid_in = 1'b1;
    byte_in       = b;
    @(posedge clk_in); #1;
    byte_valid_in = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  // A5 01 11 22 33 44 AB with ready high.
  task automatic good_packet(input string tag);
    send(8'hA5);
    check({tag, "_idle_len"}, 32'(idle_out), 32'd0);
    send(8'h01);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    check({tag, "_no_word_yet"}, 32'(word_valid_out), 32'd0);
    send(8'h44);
    check({tag, "_valid"}, 32'(word_valid_out), 32'd1);
    check({tag, "_word"}, word_out, 32'h44332211);
    check({tag, "_last"}, 32'(word_last_out), 32'd1);
    send(8'hAB);
    check({tag, "_done"}, 32'(packet_done_out), 32'd1);
    check({tag, "_err"}, 32'(error_out), 32'd0);
    check({tag, "_drained"}, 32'(word_valid_out), 32'd0);
    check({tag, "_idle_end"}, 32'(idle_out), 32'd1);
    step();
    check({tag, "_done_1cyc"}, 32'(packet_done_out), 32'd0);
  endtask

  initial begin
    int err_seen;
    #1;
    check("rst_valid", 32'(word_valid_out), 32'd0);
    check("rst_word", word_out, 32'd0);
    check("rst_last", 32'(word_last_out), 32'd0);
    check("rst_done", 32'(packet_done_out), 32'd0);
    check("rst_err", 32'(error_out), 32'd0);
    check("rst_idle", 32'(idle_out), 32'd1);
    #20;
    rst_in = 1'b0;

    good_packet("good");

    // Bad checksum: word still delivered, error only.
    send(8'hA5); send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("bad_word", word_out, 32'h44332211);
    check("bad_last", 32'(word_last_out), 32'd1);
    send(8'h00);
    check("bad_err", 32'(error_out), 32'd1);
    check("bad_done", 32'(packet_done_out), 32'd0);
    step();
    check("bad_err_1cyc", 32'(error_out), 32'd0);

    // Hunting through garbage.
    send(8'h00);
    check("hunt_idle0", 32'(idle_out), 32'd1);
    send(8'hFF);
    check("hunt_idle1", 32'(idle_out), 32'd1);
    send(8'h12);
    check("hunt_idle2", 32'(idle_out), 32'd1);
    check("hunt_no_pulse", 32'(error_out | packet_done_out), 32'd0);
    good_packet("hunt");

    // Zero-length packet returns to hunting with no pulse.
    send(8'hA5); send(8'h00);
    check("len0_idle", 32'(idle_out), 32'd1);
    check("len0_pulse", 32'(error_out | packet_done_out), 32'd0);

    // Backpressure: 3 words into a 2-deep FIFO, checksum 0x51 is correct.
    word_ready_in = 1'b0;
    send(8'hA5); send(8'h03);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check("bp_w0_valid", 32'(word_valid_out), 32'd1);
    check("bp_w0", word_out, 32'h04030201);
    for (int i = 5; i <= 12; i++) send(8'(i));
    check("bp_head_held", word_out, 32'h04030201);
    check("bp_head_last", 32'(word_last_out), 32'd0);
    send(8'h51);
    check("bp_err", 32'(error_out), 32'd1);
    check("bp_done", 32'(packet_done_out), 32'd0);
    word_ready_in = 1'b1;
    check("bp_drain0", word_out, 32'h04030201);
    step();
    check("bp_drain1_valid", 32'(word_valid_out), 32'd1);
    check("bp_drain1", word_out, 32'h08070605);
    check("bp_drain1_last", 32'(word_last_out), 32'd0);
    step();
    check("bp_empty", 32'(word_valid_out), 32'd0);

    // Reset mid-packet with a buffered word.
    word_ready_in = 1'b0;
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("mid_buffered", 32'(word_valid_out), 32'd1);
    #2;
    rst_in = 1'b1;
    #1;
    check("mid_rst_valid", 32'(word_valid_out), 32'd0);
    check("mid_rst_word", word_out, 32'd0);
    check("mid_rst_last", 32'(word_last_out), 32'd0);
    check("mid_rst_pulse", 32'(error_out | packet_done_out), 32'd0);
    check("mid_rst_idle", 32'(idle_out), 32'd1);
    #10;
    rst_in = 1'b0;
    word_ready_in = 1'b1;
    step();
    check("mid_post_pulse", 32'(error_out | packet_done_out), 32'd0);
    good_packet("post_rst");

    // Stall mid-packet.
    send(8'hA5); send(8'h02); send(8'h11);
    err_seen = 0;
    for (int i = 0; i < 1005; i++) begin
      step();
      if (error_out) err_seen++;
    end
`ifdef UART_PKT_TIMEOUT_EN
    check("to_err_pulses", 32'(err_seen), 32'd1);
    check("to_idle", 32'(idle_out), 32'd1);
`else
    check("to_err_pulses", 32'(err_seen), 32'd0);
    check("to_idle", 32'(idle_out), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
